// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED blink arbiter.
//   led_state_t    : arbiter state encoding (IDLE, PLAY, GAP)
//   calc_tick_div  : clock cycles per pattern bit
//   calc_cnt_w     : prescaler counter width for a given divider
//   DEF_*          : default parameter values
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } led_state_t;

    localparam int DEF_CLK_HZ  = 100_000_000;
    localparam int DEF_TICK_HZ = 10;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_PAT_W   = 8;
    localparam int DEF_REP_W   = 4;

    function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Counter runs 0..div-1, so it needs $clog2(div) bits (never less than 1).
    function automatic int calc_cnt_w(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV clock cycles.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset (counter to 0)
//   clear  in  synchronous restart: counter is 0 on the following cycle
//   tick   out high during the last cycle of each TICK_DIV-cycle period
// -----------------------------------------------------------------------------
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = calc_cnt_w(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded straight from the counter so the arbiter can act on it in the
    // same cycle; it must not depend on clear, which the arbiter derives from it.
    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/led_blink_arbiter.sv
// -----------------------------------------------------------------------------
// led_blink_arbiter
// Shares one LED between NUM_REQ requesters. A winner is picked round-robin,
// its pattern/repeat count are latched, and the pattern is played MSB first at
// one bit per TICK_DIV cycles, rep+1 times, followed by a TICK_DIV-cycle gap.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   req    in  [NUM_REQ]        level requests
//   pat    in  [NUM_REQ*PAT_W]  patterns, requester i at [i*PAT_W +: PAT_W]
//   rep    in  [NUM_REQ*REP_W]  repeat counts (pattern plays rep+1 times)
//   gnt    out [NUM_REQ]        one-hot registered grant
//   done   out [NUM_REQ]        one-cycle pulse on normal completion
//   busy   out                  high whenever the arbiter is not IDLE
//   led_1  out                  registered LED drive
//
// Build option LED_PREEMPT_EN: req[0] becomes urgent. A rising edge on req[0]
// while another requester is playing or in its gap switches straight to
// requester 0 (no gap, no done), and req[0] wins every IDLE arbitration.
// -----------------------------------------------------------------------------
module led_blink_arbiter
    import led_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PAT_W   = DEF_PAT_W,
    parameter int REP_W   = DEF_REP_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PAT_W-1:0] pat,
    input  logic [NUM_REQ*REP_W-1:0] rep,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     led_1
);

    localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PAT_W - 1);

    led_state_t       state_q, state_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             rr_fresh_q, rr_fresh_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [NUM_REQ-1:0] gnt_d, done_d;
    logic             led_d;

    logic             restart;
    logic             tick;
    logic             tick_clear;
    logic             urgent;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             do_grant;
    logic [IDX_W-1:0] grant_idx;

    logic [PAT_W-1:0] pat_arr [NUM_REQ];
    logic [REP_W-1:0] rep_arr [NUM_REQ];

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign pat_arr[g] = pat[g*PAT_W +: PAT_W];
        assign rep_arr[g] = rep[g*REP_W +: REP_W];
    end

    // Bit period / gap timer; restarted on every PLAY or GAP entry and held
    // at 0 while idle.
    assign tick_clear = restart || (state_q == IDLE);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

`ifdef LED_PREEMPT_EN
    logic req0_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req0_q <= 1'b0;
        end else begin
            req0_q <= req[0];
        end
    end

    // Requester 0 is never preempted, including during its own gap.
    assign urgent = req[0] && !req0_q && (state_q != IDLE) && (winner_q != '0);
`else
    assign urgent = 1'b0;
`endif

    // Round-robin search. Until the first grant after reset the search starts
    // at requester 0; afterwards it starts just past the last winner.
    always_comb begin : pick_blk
        int start_idx;
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        start_idx  = rr_fresh_q ? 0 : (int'(rr_q) + 1) % NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (start_idx + k) % NUM_REQ;
            if (!pick_found && req[IDX_W'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
`ifdef LED_PREEMPT_EN
        if (req[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        rr_d       = rr_q;
        rr_fresh_d = rr_fresh_q;
        pat_d      = pat_q;
        rep_d      = rep_q;
        bit_d      = bit_q;
        gnt_d      = '0;
        done_d     = '0;
        led_d      = 1'b0;
        restart    = 1'b0;
        do_grant   = 1'b0;
        grant_idx  = '0;

        if (urgent) begin
            do_grant  = 1'b1;
            grant_idx = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_idx;
                    end
                end
                PLAY: begin
                    // Completion is checked before abandon so a req that drops
                    // on the final tick still earns its done pulse.
                    if (tick && bit_q == '0 && rep_q == '0) begin
                        state_d = GAP;
                        restart = 1'b1;
                        done_d  = onehot(winner_q);
                    end else if (!req[winner_q]) begin
                        state_d = GAP;
                        restart = 1'b1;
                    end else begin
                        gnt_d = onehot(winner_q);
                        if (tick) begin
                            if (bit_q == '0) begin
                                rep_d = rep_q - 1'b1;
                                bit_d = BIT_TOP;
                            end else begin
                                bit_d = bit_q - 1'b1;
                            end
                        end
                        led_d = pat_q[bit_d];
                    end
                end
                GAP: begin
                    if (tick) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (do_grant) begin
            state_d    = PLAY;
            winner_d   = grant_idx;
            rr_d       = grant_idx;
            rr_fresh_d = 1'b0;
            pat_d      = pat_arr[grant_idx];
            rep_d      = rep_arr[grant_idx];
            bit_d      = BIT_TOP;
            restart    = 1'b1;
            gnt_d      = onehot(grant_idx);
            led_d      = pat_d[PAT_W-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            winner_q   <= '0;
            rr_q       <= '0;
            rr_fresh_q <= 1'b1;
            bit_q      <= BIT_TOP;
            gnt        <= '0;
            done       <= '0;
            led_1      <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            rr_q       <= rr_d;
            rr_fresh_q <= rr_fresh_d;
            bit_q      <= bit_d;
            gnt        <= gnt_d;
            done       <= done_d;
            led_1      <= led_d;
        end
    end

    // Latched pattern and repeat count: only consulted outside IDLE, after a
    // grant has loaded them, so they carry no reset.
    always_ff @(posedge clk) begin
        pat_q <= pat_d;
        rep_q <= rep_d;
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_blink_arbiter.sv
`timescale 1ns/1ps
module tb_led_blink_arbiter;

    localparam int TDIV     = 10;
    localparam int PW       = 8;
    localparam int PLAY_LEN = PW * TDIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] pat;
    logic [15:0] rep;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        led_1;

    led_blink_arbiter #(
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .NUM_REQ (4),
        .PAT_W   (8),
        .REP_W   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .pat   (pat),
        .rep   (rep),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .led_1 (led_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic       led;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Scoreboard loaders: one entry per clock cycle of expected outputs.
    task automatic push(input logic [3:0] g, input logic [3:0] d, input logic b, input logic l);
        exp_t e;
        e.gnt = g; e.done = d; e.busy = b; e.led = l;
        exp_q.push_back(e);
    endtask

    task automatic push_play(input int w, input logic [7:0] p, input int n);
        int b;
        for (int c = 0; c < n; c++) begin
            b = 7 - ((c / TDIV) % PW);
            push(4'(1 << w), 4'b0000, 1'b1, p[b[2:0]]);
        end
    endtask

    task automatic push_gap(input logic [3:0] d);
        push(4'b0000, d, 1'b1, 1'b0);
        for (int c = 1; c < TDIV; c++) push(4'b0000, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic push_idle(input int n);
        for (int c = 0; c < n; c++) push(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        exp_t e;
        int   i = 0;
        reset = 1'b1; req = 4'b0000; pat = $urandom; rep = '0;
        push_idle(4);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt || done !== e.done || busy !== e.busy || led_1 !== e.led) begin
                n_fail++;
                $display("FAIL reset[%0d]: got gnt=%b done=%b busy=%b led=%b, want gnt=%b done=%b busy=%b led=%b",
                         i, gnt, done, busy, led_1, e.gnt, e.done, e.busy, e.led);
            end
            if (i == 1) reset = 1'b0;
            i++;
        end
    endtask

    task automatic test_single();
        exp_t       e;
        int         i = 0;
        logic [7:0] p = 8'b1011_0000;
        pat[7:0] = p; rep[3:0] = 4'd0; req = 4'b0001;
        push_play(0, p, PLAY_LEN);
        push_gap(4'b0001);
        push_idle(1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt || done !== e.done || busy !== e.busy || led_1 !== e.led) begin
                n_fail++;
                $display("FAIL single[%0d]: got gnt=%b done=%b busy=%b led=%b, want gnt=%b done=%b busy=%b led=%b",
                         i, gnt, done, busy, led_1, e.gnt, e.done, e.busy, e.led);
            end
            if (i == 5) pat[7:0] = 8'h0F;
            if (i == PLAY_LEN) req = 4'b0000;
            i++;
        end
    endtask

    task automatic test_repeat();
        exp_t       e;
        int         i = 0;
        logic [7:0] p = 8'hF0;
        pat[7:0] = p; rep[3:0] = 4'd2; req = 4'b0001;
        push_play(0, p, 3 * PLAY_LEN);
        push_gap(4'b0001);
        push_idle(1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt || done !== e.done || busy !== e.busy || led_1 !== e.led) begin
                n_fail++;
                $display("FAIL repeat[%0d]: got gnt=%b done=%b busy=%b led=%b, want gnt=%b done=%b busy=%b led=%b",
                         i, gnt, done, busy, led_1, e.gnt, e.done, e.busy, e.led);
            end
            if (i == 100) rep[3:0] = 4'd0;
            if (i == 3 * PLAY_LEN) req = 4'b0000;
            i++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        int         i = 0;
        logic [7:0] p1 = 8'b1100_1010;
        logic [7:0] p3 = 8'b0111_0001;
        pat[15:8] = p1; pat[31:24] = p3; rep = '0; req = 4'b1010;
        push_play(1, p1, PLAY_LEN); push_gap(4'b0010); push_idle(1);
        push_play(3, p3, PLAY_LEN); push_gap(4'b1000); push_idle(1);
        push_play(1, p1, PLAY_LEN); push_gap(4'b0010); push_idle(1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt || done !== e.done || busy !== e.busy || led_1 !== e.led) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got gnt=%b done=%b busy=%b led=%b, want gnt=%b done=%b busy=%b led=%b",
                         i, gnt, done, busy, led_1, e.gnt, e.done, e.busy, e.led);
            end
            if (i == 2 * (PLAY_LEN + TDIV + 1) + PLAY_LEN) req = 4'b0000;
            i++;
        end
    endtask

    task automatic test_abandon();
        exp_t       e;
        int         i = 0;
        logic [7:0] p2 = 8'b1110_0111;
        pat[23:16] = p2; rep = '0; req = 4'b0100;
        push_play(2, p2, 35);
        push_gap(4'b0000);
        push_idle(1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt || done !== e.done || busy !== e.busy || led_1 !== e.led) begin
                n_fail++;
                $display("FAIL abandon[%0d]: got gnt=%b done=%b busy=%b led=%b, want gnt=%b done=%b busy=%b led=%b",
                         i, gnt, done, busy, led_1, e.gnt, e.done, e.busy, e.led);
            end
            if (i == 34) req = 4'b0000;
            i++;
        end
    endtask

    task automatic test_reset_mid_play();
        exp_t       e;
        int         i = 0;
        logic [7:0] p = 8'b1001_0110;
        pat[7:0] = p; rep = '0; req = 4'b0001;
        push_play(0, p, 50);
        push_idle(2);
        push_play(0, p, PLAY_LEN); push_gap(4'b0001); push_idle(1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt || done !== e.done || busy !== e.busy || led_1 !== e.led) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got gnt=%b done=%b busy=%b led=%b, want gnt=%b done=%b busy=%b led=%b",
                         i, gnt, done, busy, led_1, e.gnt, e.done, e.busy, e.led);
            end
            if (i == 49) begin
                reset = 1'b1;
                #1;
                n_checks++;
                if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || led_1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_async: got gnt=%b done=%b busy=%b led=%b, want all zero",
                             gnt, done, busy, led_1);
                end
            end
            if (i == 51) reset = 1'b0;
            if (i == 52 + PLAY_LEN) req = 4'b0000;
            i++;
        end
    endtask

    task automatic test_urgent_req0();
        exp_t       e;
        int         i = 0;
        logic [7:0] p3 = 8'b1010_1010;
        logic [7:0] p0 = 8'b1111_0000;
        int         drop_all;
        pat[31:24] = p3; pat[7:0] = p0; rep = '0; req = 4'b1000;
`ifdef LED_PREEMPT_EN
        push_play(3, p3, 20);
        push_play(0, p0, PLAY_LEN); push_gap(4'b0001); push_idle(1);
        drop_all = 20 + PLAY_LEN;
`else
        push_play(3, p3, PLAY_LEN); push_gap(4'b1000); push_idle(1);
        push_play(0, p0, PLAY_LEN); push_gap(4'b0001); push_idle(1);
        drop_all = (PLAY_LEN + TDIV + 1) + PLAY_LEN;
`endif
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt || done !== e.done || busy !== e.busy || led_1 !== e.led) begin
                n_fail++;
                $display("FAIL urgent_req0[%0d]: got gnt=%b done=%b busy=%b led=%b, want gnt=%b done=%b busy=%b led=%b",
                         i, gnt, done, busy, led_1, e.gnt, e.done, e.busy, e.led);
            end
            if (i == 19) req = 4'b1001;
`ifndef LED_PREEMPT_EN
            if (i == PLAY_LEN) req = 4'b0001;
`endif
            if (i == drop_all) req = 4'b0000;
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_back_to_back();
        test_abandon();
        test_reset_mid_play();
        test_urgent_req0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
